// File: rtl/stream_packetiser_pkg.sv
// Shared types and constants for the stream packetiser slice.
// STREAM_PACKETISER_CSUM_EN adds a checksum trailer word to every packet.
package stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SEQ,
    LEN,
    PAYLOAD,
    CSUM
  } pkt_state_t;

  localparam int unsigned HDR_WORDS         = 3;
  localparam logic [15:0] DEFAULT_SYNC_WORD = 16'hA55A;

  // Words written per packet in addition to the payload.
  function automatic int unsigned pkt_overhead();
`ifdef STREAM_PACKETISER_CSUM_EN
    return HDR_WORDS + 1;
`else
    return HDR_WORDS;
`endif
  endfunction

endpackage

// File: rtl/stream_packetiser_if.sv
// RX FIFO read port and TX FIFO write port seen by the packetiser.
// master: the packetiser; slave: the FIFO side.
interface stream_packetiser_if #(
  parameter int unsigned USEDW_W = 10
);
  logic [USEDW_W-1:0] rxf_usedw;
  logic [15:0]        rxf_q;
  logic               rxf_rdreq;
  logic [USEDW_W-1:0] txf_usedw;
  logic               txf_wrreq;
  logic [15:0]        txf_data;

  modport master (
    input  rxf_usedw, rxf_q, txf_usedw,
    output rxf_rdreq, txf_wrreq, txf_data
  );

  modport slave (
    output rxf_usedw, rxf_q, txf_usedw,
    input  rxf_rdreq, txf_wrreq, txf_data
  );
endinterface

// File: rtl/stream_flush_timer.sv
// Saturating idle timer: flush_due once a partial packet has waited FLUSH_CYCLES.
// FLUSH_CYCLES == 0 removes the counter and never requests a flush.
module stream_flush_timer
  import stream_pkg::*;
#(
  parameter int unsigned PKT_WORDS    = 256,
  parameter int unsigned USEDW_W      = 10,
  parameter int unsigned FLUSH_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               enable,
  input  logic               idle,
  input  logic               start,
  input  logic [USEDW_W-1:0] rxf_usedw,
  output logic               flush_due
);

  generate
    if (FLUSH_CYCLES == 0) begin : g_off
      logic unused_inputs;
      always_comb unused_inputs = ^{clk, nrst, enable, idle, start, rxf_usedw};
      always_comb flush_due = 1'b0;
    end else begin : g_on
      localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

      logic [CNT_W-1:0] cnt_q;
      logic             counting;

      // Counting only while a partial packet waits in IDLE; anything else restarts it.
      always_comb
        counting = idle && enable && !start &&
                   (rxf_usedw != '0) && (32'(rxf_usedw) < PKT_WORDS);

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          cnt_q <= '0;
        end else if (!counting) begin
          cnt_q <= '0;
        end else if (cnt_q != CNT_W'(FLUSH_CYCLES)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      always_comb flush_due = (cnt_q == CNT_W'(FLUSH_CYCLES));
    end
  endgenerate

endmodule

// File: rtl/stream_packetiser.sv
// Frames RX FIFO scan words into sync/seq/len/payload packets for the TX FIFO.
// Define STREAM_PACKETISER_CSUM_EN to append a 16-bit wrap-around checksum trailer.
module stream_packetiser
  import stream_pkg::*;
#(
  parameter int unsigned PKT_WORDS    = 256,
  parameter int unsigned USEDW_W      = 10,
  parameter int unsigned TXF_DEPTH    = 1024,
  parameter int unsigned FLUSH_CYCLES = 4096,
  parameter logic [15:0] SYNC_WORD    = DEFAULT_SYNC_WORD
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                enable,
  stream_packetiser_if.master fifo,
  output logic                busy,
  output logic [15:0]         seq
);

  localparam int unsigned OVH = pkt_overhead();

  pkt_state_t         state_q, state_d;
  logic [USEDW_W-1:0] len_q, len_d, start_len, pay_cnt_q;
  logic [15:0]        seq_q;
  logic [31:0]        rx_used, tx_space;
  logic               idle, start, full_ok, flush_ok, flush_due, pay_last, seq_inc;
`ifdef STREAM_PACKETISER_CSUM_EN
  logic [15:0]        csum_q;
`endif

  stream_flush_timer #(
    .PKT_WORDS    (PKT_WORDS),
    .USEDW_W      (USEDW_W),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) u_flush_timer (
    .clk       (clk),
    .nrst      (nrst),
    .enable    (enable),
    .idle      (idle),
    .start     (start),
    .rxf_usedw (fifo.rxf_usedw),
    .flush_due (flush_due)
  );

  // Space and data are both pre-checked so a started packet never stalls.
  always_comb begin
    idle      = (state_q == IDLE);
    rx_used   = 32'(fifo.rxf_usedw);
    tx_space  = 32'(TXF_DEPTH) - 32'(fifo.txf_usedw);
    full_ok   = (rx_used >= PKT_WORDS) && (tx_space >= PKT_WORDS + OVH);
    flush_ok  = flush_due && (rx_used != 0) && (tx_space >= rx_used + OVH);
    start     = idle && enable && (full_ok || flush_ok);
    start_len = (rx_used >= PKT_WORDS) ? USEDW_W'(PKT_WORDS) : fifo.rxf_usedw;
    pay_last  = (pay_cnt_q == len_q - 1'b1);
  end

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    fifo.rxf_rdreq = 1'b0;
    fifo.txf_wrreq = 1'b0;
    fifo.txf_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SYNC;
          len_d   = start_len;
        end
      end
      SYNC: begin
        fifo.txf_wrreq = 1'b1;
        fifo.txf_data  = SYNC_WORD;
        state_d        = SEQ;
      end
      SEQ: begin
        fifo.txf_wrreq = 1'b1;
        fifo.txf_data  = seq_q;
        state_d        = LEN;
      end
      LEN: begin
        fifo.txf_wrreq = 1'b1;
        fifo.txf_data  = 16'(len_q);
        fifo.rxf_rdreq = 1'b1;
        state_d        = PAYLOAD;
      end
      // Reads run one word ahead of writes, so the final write issues no read.
      PAYLOAD: begin
        fifo.txf_wrreq = 1'b1;
        fifo.txf_data  = fifo.rxf_q;
        fifo.rxf_rdreq = !pay_last;
        if (pay_last) begin
`ifdef STREAM_PACKETISER_CSUM_EN
          state_d = CSUM;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef STREAM_PACKETISER_CSUM_EN
      CSUM: begin
        fifo.txf_wrreq = 1'b1;
        fifo.txf_data  = csum_q;
        state_d        = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    seq_inc = !idle && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      pay_cnt_q <= '0;
      seq_q     <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      if (state_q == LEN) begin
        pay_cnt_q <= '0;
      end else if (state_q == PAYLOAD) begin
        pay_cnt_q <= pay_cnt_q + 1'b1;
      end
      if (seq_inc) begin
        seq_q <= seq_q + 16'd1;
      end
    end
  end

`ifdef STREAM_PACKETISER_CSUM_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      csum_q <= '0;
    end else begin
      unique case (state_q)
        SYNC:    csum_q <= '0;
        SEQ:     csum_q <= csum_q + seq_q;
        LEN:     csum_q <= csum_q + 16'(len_q);
        PAYLOAD: csum_q <= csum_q + fifo.rxf_q;
        default: csum_q <= csum_q;
      endcase
    end
  end
`endif

  always_comb begin
    busy = !idle;
    seq  = seq_q;
  end

endmodule

// File: tb/tb_stream_packetiser.sv
// Directed bench for stream_packetiser with PKT_WORDS=4, FLUSH_CYCLES=8, TXF_DEPTH=16.
module tb_stream_packetiser;
  import stream_pkg::*;

  localparam int unsigned PKT_WORDS    = 4;
  localparam int unsigned USEDW_W      = 10;
  localparam int unsigned TXF_DEPTH    = 16;
  localparam int unsigned FLUSH_CYCLES = 8;
  localparam int unsigned OVH          = pkt_overhead();

  typedef logic [15:0] word_q_t[$];

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic enable = 1'b0;
  logic en_nf = 1'b0;
  logic [USEDW_W-1:0] nf_usedw = '0;
  logic busy, busy_nf;
  logic [15:0] seq, seq_nf;
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [15:0] rx_mem [0:63];
  int unsigned rx_wr = 0;
  int unsigned rx_rd = 0;

  stream_packetiser_if #(.USEDW_W(USEDW_W)) bus ();
  stream_packetiser_if #(.USEDW_W(USEDW_W)) bus_nf ();

  stream_packetiser #(
    .PKT_WORDS    (PKT_WORDS),
    .USEDW_W      (USEDW_W),
    .TXF_DEPTH    (TXF_DEPTH),
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .SYNC_WORD    (16'hA55A)
  ) dut (
    .clk    (clk),
    .nrst   (nrst),
    .enable (enable),
    .fifo   (bus.master),
    .busy   (busy),
    .seq    (seq)
  );

  stream_packetiser #(
    .PKT_WORDS    (PKT_WORDS),
    .USEDW_W      (USEDW_W),
    .TXF_DEPTH    (TXF_DEPTH),
    .FLUSH_CYCLES (0),
    .SYNC_WORD    (16'hA55A)
  ) dut_nf (
    .clk    (clk),
    .nrst   (nrst),
    .enable (en_nf),
    .fifo   (bus_nf.master),
    .busy   (busy_nf),
    .seq    (seq_nf)
  );

  always #5 clk = ~clk;

  // Non-show-ahead RX FIFO: data appears the cycle after rdreq; cleared by nrst.
  assign bus.rxf_usedw    = USEDW_W'(rx_wr - rx_rd);
  assign bus_nf.rxf_usedw = nf_usedw;
  assign bus_nf.rxf_q     = '0;
  assign bus_nf.txf_usedw = '0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rx_rd     <= rx_wr;
      bus.rxf_q <= '0;
    end else if (bus.rxf_rdreq) begin
      bus.rxf_q <= rx_mem[rx_rd % 64];
      rx_rd     <= rx_rd + 1;
    end
  end

  function automatic word_q_t seq_words(input logic [15:0] first, input int unsigned n);
    word_q_t q;
    for (int unsigned i = 0; i < n; i++) q.push_back(first + 16'(i));
    return q;
  endfunction

  function automatic word_q_t build_pkt(input logic [15:0] s, input word_q_t pl);
    word_q_t q;
`ifdef STREAM_PACKETISER_CSUM_EN
    logic [15:0] sum;
    sum = s + 16'(pl.size());
    foreach (pl[i]) sum = sum + pl[i];
`endif
    q.push_back(16'hA55A);
    q.push_back(s);
    q.push_back(16'(pl.size()));
    foreach (pl[i]) q.push_back(pl[i]);
`ifdef STREAM_PACKETISER_CSUM_EN
    q.push_back(sum);
`endif
    return q;
  endfunction

  task automatic push_words(input word_q_t w);
    foreach (w[i]) begin
      rx_mem[rx_wr % 64] = w[i];
      rx_wr = rx_wr + 1;
    end
  endtask

  task automatic test_reset();
    bus.txf_usedw = '0;
    nrst = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.txf_wrreq !== 1'b0) begin errors++; $display("FAIL reset_wrreq: got %b want 0", bus.txf_wrreq); end
    checks++;
    if (bus.rxf_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq: got %b want 0", bus.rxf_rdreq); end
    checks++;
    if (bus.txf_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", bus.txf_data); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (seq !== 16'h0000) begin errors++; $display("FAIL reset_seq: got %h want 0000", seq); end
    nrst = 1'b1;
    @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic test_full_packet();
    word_q_t exp;
    logic exp_rd;
    exp = build_pkt(16'h0000, seq_words(16'd1, 4));
    push_words(seq_words(16'd1, 4));
    foreach (exp[i]) begin
      @(negedge clk);
      exp_rd = (i >= 2) && (i < 2 + int'(PKT_WORDS));
      checks++;
      if (bus.txf_wrreq !== 1'b1 || bus.txf_data !== exp[i] || bus.rxf_rdreq !== exp_rd || busy !== 1'b1) begin
        errors++;
        $display("FAIL full_word%0d: wrreq=%b data=%h rdreq=%b busy=%b want 1 %h %b 1",
                 i, bus.txf_wrreq, bus.txf_data, bus.rxf_rdreq, busy, exp[i], exp_rd);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.txf_wrreq !== 1'b0 || busy !== 1'b0 || seq !== 16'h0001) begin
      errors++;
      $display("FAIL full_end: wrreq=%b busy=%b seq=%h want 0 0 0001", bus.txf_wrreq, busy, seq);
    end
  endtask

  task automatic test_tx_gating();
    word_q_t exp;
    int unsigned blocked;
    blocked = TXF_DEPTH - (PKT_WORDS + OVH) + 1;
    exp = build_pkt(16'h0001, seq_words(16'd5, 4));
    bus.txf_usedw = USEDW_W'(blocked);
    push_words(seq_words(16'd5, 4));
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b0 || busy !== 1'b0 || bus.rxf_rdreq !== 1'b0) begin
        errors++;
        $display("FAIL gate_blocked: wrreq=%b busy=%b rdreq=%b want 0 0 0", bus.txf_wrreq, busy, bus.rxf_rdreq);
      end
    end
    bus.txf_usedw = USEDW_W'(blocked - 1);
    foreach (exp[i]) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b1 || bus.txf_data !== exp[i]) begin
        errors++;
        $display("FAIL gate_word%0d: wrreq=%b data=%h want 1 %h", i, bus.txf_wrreq, bus.txf_data, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || seq !== 16'h0002) begin
      errors++; $display("FAIL gate_end: busy=%b seq=%h want 0 0002", busy, seq);
    end
    bus.txf_usedw = '0;
  endtask

  task automatic test_flush();
    word_q_t exp;
    exp = build_pkt(16'h0002, seq_words(16'd7, 2));
    push_words(seq_words(16'd7, 2));
    for (int k = 1; k <= int'(FLUSH_CYCLES); k++) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL flush_wait%0d: wrreq=%b busy=%b want 0 0", k, bus.txf_wrreq, busy);
      end
    end
    foreach (exp[i]) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b1 || bus.txf_data !== exp[i]) begin
        errors++;
        $display("FAIL flush_word%0d: wrreq=%b data=%h want 1 %h", i, bus.txf_wrreq, bus.txf_data, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || seq !== 16'h0003 || bus.rxf_usedw !== '0) begin
      errors++;
      $display("FAIL flush_end: busy=%b seq=%h usedw=%0d want 0 0003 0", busy, seq, bus.rxf_usedw);
    end
  endtask

  task automatic test_no_flush();
    en_nf = 1'b1;
    nf_usedw = USEDW_W'(2);
    repeat (20) begin
      @(negedge clk);
      checks++;
      if (bus_nf.txf_wrreq !== 1'b0 || bus_nf.rxf_rdreq !== 1'b0 || busy_nf !== 1'b0 || seq_nf !== 16'h0000) begin
        errors++;
        $display("FAIL noflush: wrreq=%b rdreq=%b busy=%b seq=%h want 0 0 0 0000",
                 bus_nf.txf_wrreq, bus_nf.rxf_rdreq, busy_nf, seq_nf);
      end
    end
    en_nf = 1'b0;
    nf_usedw = '0;
  endtask

  task automatic test_back_to_back();
    word_q_t exp_a, exp_b;
    exp_a = build_pkt(16'h0003, seq_words(16'd9, 4));
    exp_b = build_pkt(16'h0004, seq_words(16'd13, 4));
    push_words(seq_words(16'd9, 8));
    foreach (exp_a[i]) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b1 || bus.txf_data !== exp_a[i]) begin
        errors++;
        $display("FAIL b2b_a_word%0d: wrreq=%b data=%h want 1 %h", i, bus.txf_wrreq, bus.txf_data, exp_a[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.txf_wrreq !== 1'b0 || busy !== 1'b0 || seq !== 16'h0004) begin
      errors++;
      $display("FAIL b2b_gap: wrreq=%b busy=%b seq=%h want 0 0 0004", bus.txf_wrreq, busy, seq);
    end
    foreach (exp_b[i]) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b1 || bus.txf_data !== exp_b[i]) begin
        errors++;
        $display("FAIL b2b_b_word%0d: wrreq=%b data=%h want 1 %h", i, bus.txf_wrreq, bus.txf_data, exp_b[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || seq !== 16'h0005) begin
      errors++; $display("FAIL b2b_end: busy=%b seq=%h want 0 0005", busy, seq);
    end
  endtask

  task automatic test_enable();
    word_q_t exp_a, exp_b;
    exp_a = build_pkt(16'h0005, seq_words(16'd21, 4));
    exp_b = build_pkt(16'h0006, seq_words(16'd25, 4));
    enable = 1'b0;
    push_words(seq_words(16'd21, 8));
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL en_off: wrreq=%b busy=%b want 0 0", bus.txf_wrreq, busy);
      end
    end
    enable = 1'b1;
    foreach (exp_a[i]) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b1 || bus.txf_data !== exp_a[i]) begin
        errors++;
        $display("FAIL en_drop_word%0d: wrreq=%b data=%h want 1 %h", i, bus.txf_wrreq, bus.txf_data, exp_a[i]);
      end
      if (i == 0) enable = 1'b0;
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b0 || busy !== 1'b0 || seq !== 16'h0006) begin
        errors++;
        $display("FAIL en_hold: wrreq=%b busy=%b seq=%h want 0 0 0006", bus.txf_wrreq, busy, seq);
      end
    end
    enable = 1'b1;
    foreach (exp_b[i]) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b1 || bus.txf_data !== exp_b[i]) begin
        errors++;
        $display("FAIL en_resume_word%0d: wrreq=%b data=%h want 1 %h", i, bus.txf_wrreq, bus.txf_data, exp_b[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || seq !== 16'h0007) begin
      errors++; $display("FAIL en_end: busy=%b seq=%h want 0 0007", busy, seq);
    end
  endtask

  task automatic test_reset_mid();
    word_q_t exp;
    exp = build_pkt(16'h0007, seq_words(16'd41, 4));
    push_words(seq_words(16'd41, 4));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b1 || bus.txf_data !== exp[i]) begin
        errors++;
        $display("FAIL rstmid_word%0d: wrreq=%b data=%h want 1 %h", i, bus.txf_wrreq, bus.txf_data, exp[i]);
      end
    end
    nrst = 1'b0;
    #1;
    checks++;
    if (bus.txf_wrreq !== 1'b0 || bus.rxf_rdreq !== 1'b0 || bus.txf_data !== 16'h0000 ||
        busy !== 1'b0 || seq !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_async: wrreq=%b rdreq=%b data=%h busy=%b seq=%h want 0 0 0000 0 0000",
               bus.txf_wrreq, bus.rxf_rdreq, bus.txf_data, busy, seq);
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b0 || busy !== 1'b0 || seq !== 16'h0000) begin
        errors++;
        $display("FAIL rstmid_after: wrreq=%b busy=%b seq=%h want 0 0 0000", bus.txf_wrreq, busy, seq);
      end
    end
    exp = build_pkt(16'h0000, seq_words(16'd51, 4));
    push_words(seq_words(16'd51, 4));
    foreach (exp[i]) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b1 || bus.txf_data !== exp[i]) begin
        errors++;
        $display("FAIL rstmid_recover_word%0d: wrreq=%b data=%h want 1 %h", i, bus.txf_wrreq, bus.txf_data, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || seq !== 16'h0001) begin
      errors++; $display("FAIL rstmid_end: busy=%b seq=%h want 0 0001", busy, seq);
    end
  endtask

  task automatic test_seq_wrap();
    word_q_t exp;
    enable = 1'b0;
    @(negedge clk);
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    @(negedge clk);
    checks++;
    if (seq !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: seq=%h want ffff", seq); end
    exp = build_pkt(16'hFFFF, seq_words(16'd31, 4));
    push_words(seq_words(16'd31, 4));
    enable = 1'b1;
    foreach (exp[i]) begin
      @(negedge clk);
      checks++;
      if (bus.txf_wrreq !== 1'b1 || bus.txf_data !== exp[i]) begin
        errors++;
        $display("FAIL wrap_word%0d: wrreq=%b data=%h want 1 %h", i, bus.txf_wrreq, bus.txf_data, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || seq !== 16'h0000) begin
      errors++; $display("FAIL wrap_end: busy=%b seq=%h want 0 0000", busy, seq);
    end
  endtask

  initial begin
    test_reset();
    test_full_packet();
    test_tx_gating();
    test_flush();
    test_no_flush();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_seq_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_packetiser.md
Name: stream_packetiser

Overview:
- Sequencer between the receive stream FIFO read port and the transmit stream FIFO write port of the film-scanner streaming path.
- Pulls 16-bit scan words from the RX FIFO and emits framed packets into the TX FIFO: sync word, sequence number, payload length, payload.
- Only starts a packet when the whole packet fits, so each packet is written contiguously with no stalls.
- A flush timer sends a short packet when the RX FIFO holds a partial packet for too long.

Parameters:
- PKT_WORDS, 256, full payload length in words; 1..2^USEDW_W-1.
- USEDW_W, 10, width of both FIFO used-word counts.
- TXF_DEPTH, 1024, TX FIFO depth in words.
- FLUSH_CYCLES, 4096, idle cycles before a partial packet is flushed; 0 disables flushing.
- SYNC_WORD, 16'hA55A, first header word.

Ports:
- clk  in  1  single block clock; also the RX FIFO read clock and the TX FIFO write clock.
- nrst  in  1  asynchronous active-low reset.
- enable  in  1  allows new packets to start; a packet in progress always completes.
- rxf_usedw  in  USEDW_W  RX FIFO read-side used-word count.
- rxf_q  in  16  RX FIFO data; non-show-ahead, valid 1 cycle after rxf_rdreq.
- rxf_rdreq  out  1  RX FIFO read request.
- txf_usedw  in  USEDW_W  TX FIFO write-side used-word count.
- txf_wrreq  out  1  TX FIFO write request.
- txf_data  out  16  TX FIFO write data.
- busy  out  1  high in every state except IDLE.
- seq  out  16  sequence number of the next packet.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, seq=0 and the flush counter is 0. Reset is asynchronous and may occur mid-packet; the partial packet is dropped (both FIFOs are cleared by the same nrst).
- OVH = 3 header words, or 4 with the trailer enabled.
- Start condition, evaluated in IDLE with enable=1:
  - full start when rxf_usedw >= PKT_WORDS, with len=PKT_WORDS;
  - flush start when the flush counter == FLUSH_CYCLES (FLUSH_CYCLES != 0) and rxf_usedw > 0, with len=rxf_usedw.
  - Both also require TXF_DEPTH - txf_usedw >= len + OVH.
  - len is latched when IDLE is exited.
- Flush counter:
  - increments in IDLE while enable=1 and 0 < rxf_usedw < PKT_WORDS;
  - saturates at FLUSH_CYCLES, including while TX space is insufficient;
  - clears when rxf_usedw is 0 or >= PKT_WORDS, on leaving IDLE, or when enable=0.
- FSM: IDLE -> SYNC -> SEQ -> LEN -> PAYLOAD -> [CSUM] -> IDLE.
  - SYNC: txf_wrreq=1, txf_data=SYNC_WORD.
  - SEQ: txf_wrreq=1, txf_data=seq.
  - LEN: txf_wrreq=1, txf_data=len (zero-extended); rxf_rdreq=1 for the first payload word.
  - PAYLOAD: exactly len cycles with txf_wrreq=1 and txf_data=rxf_q. rxf_rdreq=1 while fewer than len reads have been issued (len-1 cycles). Exits after the len-th write.
  - CSUM: present only with the trailer enabled.
- Latency: first txf_wrreq is 1 cycle after the start condition is sampled. A packet occupies exactly OVH+len consecutive cycles with txf_wrreq high.
- seq increments by 1 on return to IDLE and wraps 16'hFFFF -> 0.
- Back-to-back packets: one IDLE cycle minimum between packets.
- The block never writes when TX space is insufficient and never reads when the RX FIFO is empty (space and data are pre-checked). A FIFO overflow is an upstream error and is not handled.
- enable dropped mid-packet: the packet completes; the FSM stays in IDLE until enable=1.

Optional Feature:
- Macro: STREAM_PACKETISER_CSUM_EN.
- Defined: OVH=4. A CSUM state writes the trailer word = 16-bit wrap-around sum of seq, len and all payload words. The accumulator clears in SYNC.
- Undefined: OVH=3, no CSUM state, no accumulator logic.

Decomposition:
- Shared package stream_pkg holds:
  - the state enum typedef (IDLE, SYNC, SEQ, LEN, PAYLOAD, CSUM);
  - HDR_WORDS=3;
  - the default SYNC_WORD;
  - function pkt_overhead() returning OVH under the macro.
- One sub-module, stream_flush_timer: the saturating flush counter with its clear/increment rules, outputting flush_due.

Test Plan (PKT_WORDS=4, FLUSH_CYCLES=8, TXF_DEPTH=16):
- Full packet: rxf_usedw=4 with words 1,2,3,4, txf_usedw=0 -> TX writes A55A,0000,0004,0001,0002,0003,0004 on consecutive cycles, then seq=1.
- TX space gating: rxf_usedw=4, txf_usedw=10 (space 6 < 7) -> no write, busy=0; lower txf_usedw to 9 -> packet starts the next cycle.
- Flush: rxf_usedw held at 2 (words 7,8) for 8 IDLE cycles -> packet A55A,seq,0002,0007,0008; no flush with FLUSH_CYCLES=0.
- Seq wrap: preload seq to FFFF via 65535 packets or force, then send one packet -> header seq=FFFF, then seq=0000.
- Reset mid-PAYLOAD: nrst low after 2 payload writes -> all outputs 0 immediately; after release, seq=0 and the FSM is in IDLE.
- With STREAM_PACKETISER_CSUM_EN, full packet 1,2,3,4 at seq=0 -> trailer 000E; packet is 8 cycles long.
